// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame-state type and defaults for uart_tx and uart_rx.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int OVERSAMPLE_RATE = 16;
  localparam int DEFAULT_DATA_WIDTH = 8;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: word handshake between a producer and the UART transmitter.
interface uart_tx_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_done;
  modport master(output tx_data, tx_valid, input tx_ready, tx_done);
  modport slave(input tx_data, tx_valid, output tx_ready, tx_done);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter; tick marks the last cycle of a period, pre_tick the one before.
module uart_baud_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DIVISOR = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);
  localparam int CPB = CLK_FREQ / (BAUD_RATE * DIVISOR);
  localparam int W = $clog2(CPB);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CPB - 1);
  assign pre_tick = cnt == W'(CPB - 2);
  always_ff @(posedge clk)
    if (rst || restart) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises one word per handshake as start, LSB-first data, even parity, stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic clk,
  input  logic reset,
  uart_tx_if.slave tx,
  output logic TxD
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int IW = $clog2(DATA_WIDTH) + 1;
  if (CPB < 2 || DATA_WIDTH < 1) begin : g_bad_params
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be >= 2 and DATA_WIDTH >= 1");
  end
  uart_state_t state;
  logic [DATA_WIDTH-1:0] sh;
  logic [IW-1:0] idx;
  logic par, done, tick, pre_tick, accept;
  assign tx.tx_ready = state == IDLE && !reset;
  assign tx.tx_done = done;
  assign accept = tx.tx_ready && tx.tx_valid;
  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DIVISOR(1)) u_baud (
    .clk(clk), .rst(reset), .restart(accept), .tick(tick), .pre_tick(pre_tick)
  );
  // done is registered one cycle early so it lands on the final stop-bit cycle
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      TxD <= 1'b1;
      done <= 1'b0;
      sh <= '0;
      idx <= '0;
      par <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (tx.tx_valid) begin
          state <= START;
          TxD <= 1'b0;
          sh <= tx.tx_data;
        end
        START: if (tick) begin
          state <= DATA;
          TxD <= sh[0];
          sh <= sh >> 1;
          par <= ^sh;
          idx <= '0;
        end
        DATA: if (tick) begin
          if (idx == IW'(DATA_WIDTH - 1)) begin
            state <= PARITY;
            TxD <= par;
          end else begin
            TxD <= sh[0];
            sh <= sh >> 1;
            idx <= idx + IW'(1);
          end
        end
        PARITY: if (tick) begin
          state <= STOP;
          TxD <= 1'b1;
        end
        STOP: begin
          done <= pre_tick;
          if (tick) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          TxD <= 1'b1;
        end
      endcase
    end
endmodule
